ysyx_uopq: RTL and testbench
============================

Name: ysyx_uopq

Overview:
Parametrised multi-lane in-order micro-op queue between rename and issue. Buffers up to DEPTH entries, each a ysyx_pkg::uop_t paired with a ysyx_pkg::prd_t. Accepts up to WIDTH entries per cycle and releases up to WIDTH entries per cycle, both in program order. flush_i empties the queue on redirect or trap.

Parameters:
DEPTH, 8, number of entries; power of two, at least 2*WIDTH.
WIDTH, 2, enqueue/dequeue lanes per cycle; 1..4.
CNTW, $clog2(DEPTH+1), occupancy counter width (derived).

Ports:
clock  in  1  clock, rising edge.
reset  in  1  synchronous, active-low; 0 at a rising edge resets the block.
flush_i  in  1  discard all entries, including this cycle's enqueue.
enq_valid_i  in  WIDTH  per-lane valid; must be prefix-contiguous (lane i set implies lane i-1 set).
enq_uop_i  in  WIDTH x uop_t  micro-op per lane.
enq_prd_i  in  WIDTH x prd_t  renamed operands per lane.
enq_ready_o  out  1  whole-group accept; 1 iff free entries >= WIDTH.
deq_valid_o  out  WIDTH  lane i valid iff count > i.
deq_uop_o  out  WIDTH x uop_t  entry at head+i.
deq_prd_o  out  WIDTH x prd_t  entry at head+i.
deq_ready_i  in  WIDTH  per-lane consume; only the leading run of valid&ready lanes is taken.
count_o  out  CNTW  current occupancy.
full_o  out  1  count == DEPTH.
empty_o  out  1  count == 0.

Behaviour:
- Storage: circular array of DEPTH {uop_t, prd_t} entries. head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is kept as a separate register.
- Reset (reset==0 at a clock edge): head=0, tail=0, count=0. Outputs after reset: deq_valid_o=0, count_o=0, empty_o=1, full_o=0, enq_ready_o=1. Entry contents are not reset; deq_uop_o/deq_prd_o are don't-care while invalid. Reset takes priority over flush_i and over all handshakes.
- Enqueue count: n_enq = popcount(enq_valid_i) when enq_ready_o=1, else 0.
- Enqueue placement: lane i writes to slot (tail+i) mod DEPTH. tail += n_enq.
- Enqueue is all-or-nothing. A group offered while enq_ready_o=0 is held by the producer; no partial accept.
- Dequeue count: n_deq = number of leading lanes k with deq_valid_o[k] & deq_ready_i[k]. The first zero ends the run, so a ready bit on a later lane is ignored. head += n_deq.
- Per cycle: count_next = count + n_enq - n_deq.
- enq_ready_o is computed from registered count only (DEPTH - count >= WIDTH). Same-cycle dequeue does not grant credit. No combinational path from deq_ready_i to enq_ready_o.
- Latency: an entry enqueued in cycle t is visible on deq_*_o in cycle t+1 at the earliest. No bypass.
- Outputs deq_*_o are read combinationally from registered array/head.
- flush_i=1: next state head=0, tail=0, count=0. This cycle's enqueue and dequeue are discarded (no writes). deq_valid_o still shows pre-flush contents in the flush cycle; consumers must gate with flush.
- Wrap-around: a group straddling slot DEPTH-1 → 0 is split across the boundary correctly.
- Simultaneous enqueue and dequeue with count == DEPTH-WIDTH is legal; the result is count + n_enq - n_deq.
- Assertions (simulation only):
  - enq_valid_i is prefix-contiguous.
  - count never exceeds DEPTH.
  - no dequeue of invalid lanes is counted.

Decomposition:
- Shared package (ysyx_pkg): add uopq_ent_t = packed struct {uop_t uop; prd_t prd;}. Also add default constant YSYX_UOPQ_DEPTH in the shared header.
- Sub-module: ysyx_uopq_lead_cnt, a combinational leading-ones counter (WIDTH in, $clog2(WIDTH+1) out). It computes n_deq and is reusable by the rename and commit stages.
- Storage is a flop array within ysyx_uopq.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then reset=1 → count_o=0, empty_o=1, enq_ready_o=1, deq_valid_o=2'b00.
- Fill (DEPTH=8, WIDTH=2): enqueue 2'b11 with pc=0x80000000..0x8000001C over 4 cycles, no dequeue.
  - enq_ready_o drops when count_o=7 is reached? No: it drops at count_o=8.
  - Required: full_o=1, enq_ready_o=0, deq_uop_o[0].pc=0x80000000.
- Partial dequeue order: from the full state, deq_ready_i=2'b10 → nothing taken. Then deq_ready_i=2'b01 → one taken, count_o=7, deq_uop_o[0].pc=0x80000004.
- Wrap-around: dequeue and enqueue at 2/cycle for 10 cycles with incrementing pc.
  - Required: dequeued pc sequence is strictly increasing by 4, with no gap or duplicate across slot 7 → 0.
- Credit rule: count_o=7, enq_valid_i=2'b11, deq_ready_i=2'b11 → enq_ready_o=0. The group is not written; count_o becomes 5 next cycle.
- Flush and reset mid-operation:
  - count_o=5, flush_i=1 with enq_valid_i=2'b11 → next cycle count_o=0, empty_o=1; the flushed-cycle data never appears.
  - Repeat with reset=0 and flush_i=0 → same result.

Source files
------------

// File: rtl/ysyx_pkg.sv
// Shared types and defaults for the rename/issue micro-op path.
package ysyx_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 8;
  localparam int unsigned PREG_W = 6;

  localparam int unsigned YSYX_UOPQ_DEPTH = 8;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [OP_W-1:0] op;
  } uop_t;

  typedef struct packed {
    logic [PREG_W-1:0] rd;
    logic [PREG_W-1:0] rs1;
    logic [PREG_W-1:0] rs2;
  } prd_t;

  typedef struct packed {
    uop_t uop;
    prd_t prd;
  } uopq_ent_t;

endpackage

// File: rtl/ysyx_uopq_lead_cnt.sv
// Leading-ones counter: number of consecutive set bits starting at bit 0.
module ysyx_uopq_lead_cnt #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0]             bits,
  output logic [$clog2(W+1)-1:0]   cnt
);

  localparam int unsigned CW = $clog2(W + 1);

  logic run;

  // the run ends at the first zero; later ones are ignored
  always_comb begin
    run = 1'b1;
    cnt = '0;
    for (int unsigned i = 0; i < W; i++) begin
      run = run & bits[i];
      cnt = cnt + CW'(run);
    end
  end

endmodule

// File: rtl/ysyx_uopq.sv
// In-order multi-lane micro-op queue between rename and issue.
module ysyx_uopq
  import ysyx_pkg::*;
#(
  parameter int unsigned DEPTH = YSYX_UOPQ_DEPTH,
  parameter int unsigned WIDTH = 2,
  parameter int unsigned CNTW  = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush_i,
  input  logic [WIDTH-1:0]    enq_valid_i,
  input  uop_t [WIDTH-1:0]    enq_uop_i,
  input  prd_t [WIDTH-1:0]    enq_prd_i,
  output logic                enq_ready_o,
  output logic [WIDTH-1:0]    deq_valid_o,
  output uop_t [WIDTH-1:0]    deq_uop_o,
  output prd_t [WIDTH-1:0]    deq_prd_o,
  input  logic [WIDTH-1:0]    deq_ready_i,
  output logic [CNTW-1:0]     count_o,
  output logic                full_o,
  output logic                empty_o
);

  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned LCW  = $clog2(WIDTH + 1);

  uopq_ent_t         mem [DEPTH];
  logic [PTRW-1:0]   head;
  logic [PTRW-1:0]   tail;
  logic [CNTW-1:0]   count;
  logic [LCW-1:0]    n_enq;
  logic [LCW-1:0]    n_deq;

  // credit comes from registered occupancy only; same-cycle dequeue does not help
  assign enq_ready_o = (count <= CNTW'(DEPTH - WIDTH));
  assign count_o     = count;
  assign full_o      = (count == CNTW'(DEPTH));
  assign empty_o     = (count == '0);

  // enqueue size: whole group or nothing
  always_comb begin
    n_enq = '0;
    if (enq_ready_o) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        n_enq = n_enq + LCW'(enq_valid_i[i]);
      end
    end
  end

  // dequeue window read straight from the array at head
  always_comb begin
    deq_valid_o = '0;
    deq_uop_o   = '0;
    deq_prd_o   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      deq_valid_o[i] = (count > CNTW'(i));
      deq_uop_o[i]   = mem[head + PTRW'(i)].uop;
      deq_prd_o[i]   = mem[head + PTRW'(i)].prd;
    end
  end

  ysyx_uopq_lead_cnt #(.W(WIDTH)) u_deq_cnt (
    .bits (deq_valid_o & deq_ready_i),
    .cnt  (n_deq)
  );

  // pointers and occupancy; reset beats flush beats handshakes
  always_ff @(posedge clock) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTRW'(n_deq);
      tail  <= tail + PTRW'(n_enq);
      count <= count + CNTW'(n_enq) - CNTW'(n_deq);
    end
  end

  // entry storage; lanes land at tail+i and wrap naturally with the pointer width
  always_ff @(posedge clock) begin
    if (reset && !flush_i && enq_ready_o) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (enq_valid_i[i]) begin
          mem[tail + PTRW'(i)] <= '{uop: enq_uop_i[i], prd: enq_prd_i[i]};
        end
      end
    end
  end

  // protocol and occupancy sanity checks
  always_ff @(posedge clock) begin
    if (reset) begin
      assert (((enq_valid_i >> 1) & ~enq_valid_i) == '0)
        else $error("uopq: enq_valid_i is not prefix-contiguous");
      assert (count <= CNTW'(DEPTH))
        else $error("uopq: occupancy above DEPTH");
      assert (CNTW'(n_deq) <= count)
        else $error("uopq: dequeue counted an invalid lane");
    end
  end

endmodule

// File: tb/tb_ysyx_uopq.sv
// Directed bench for ysyx_uopq (DEPTH=8, WIDTH=2).
module tb_ysyx_uopq;
  import ysyx_pkg::*;

  logic        clock;
  logic        reset;
  logic        flush_i;
  logic [1:0]  enq_valid_i;
  uop_t [1:0]  enq_uop_i;
  prd_t [1:0]  enq_prd_i;
  logic        enq_ready_o;
  logic [1:0]  deq_valid_o;
  uop_t [1:0]  deq_uop_o;
  prd_t [1:0]  deq_prd_o;
  logic [1:0]  deq_ready_i;
  logic [3:0]  count_o;
  logic        full_o;
  logic        empty_o;

  int total;
  int passed;
  int failed;

  ysyx_uopq #(.DEPTH(8), .WIDTH(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush_i     (flush_i),
    .enq_valid_i (enq_valid_i),
    .enq_uop_i   (enq_uop_i),
    .enq_prd_i   (enq_prd_i),
    .enq_ready_o (enq_ready_o),
    .deq_valid_o (deq_valid_o),
    .deq_uop_o   (deq_uop_o),
    .deq_prd_o   (deq_prd_o),
    .deq_ready_i (deq_ready_i),
    .count_o     (count_o),
    .full_o      (full_o),
    .empty_o     (empty_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // lane 1 carries pc0+4; rd tracks pc[7:2] so payload can be cross-checked
  task automatic drive(input logic [1:0] ev, input logic [31:0] pc0,
                       input logic [1:0] dr, input logic fl);
    logic [31:0] pc1;
    pc1 = pc0 + 32'd4;
    enq_valid_i  = ev;
    enq_uop_i[0] = '{pc: pc0, op: 8'h13};
    enq_uop_i[1] = '{pc: pc1, op: 8'h33};
    enq_prd_i[0] = '{rd: pc0[7:2], rs1: pc0[7:2] + 6'd1, rs2: 6'd0};
    enq_prd_i[1] = '{rd: pc1[7:2], rs1: pc1[7:2] + 6'd1, rs2: 6'd0};
    deq_ready_i  = dr;
    flush_i      = fl;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] enq_pc;
    total  = 0;
    passed = 0;
    failed = 0;
    reset  = 1'b0;
    drive(2'b00, 32'h0, 2'b00, 1'b0);

    // reset, then idle
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_enq_ready", 32'(enq_ready_o), 32'd1);
    chk("rst_deq_valid", 32'(deq_valid_o), 32'd0);

    // fill with 4 pairs, no dequeue
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 32'h8000_0000 + 32'(8 * k), 2'b00, 1'b0);
      if (k == 0) chk("no_bypass", 32'(deq_valid_o), 32'd0);
      if (k == 3) chk("ready_at_6", 32'(enq_ready_o), 32'd1);
      tick();
      chk("fill_count", 32'(count_o), 32'(2 * (k + 1)));
    end
    drive(2'b00, 32'h0, 2'b00, 1'b0);
    #1;
    chk("full_flag", 32'(full_o), 32'd1);
    chk("full_enq_ready", 32'(enq_ready_o), 32'd0);
    chk("full_head_pc0", deq_uop_o[0].pc, 32'h8000_0000);
    chk("full_head_pc1", deq_uop_o[1].pc, 32'h8000_0004);

    // ready only on lane 1: nothing leaves
    drive(2'b00, 32'h0, 2'b10, 1'b0);
    tick();
    chk("lane1_only_count", 32'(count_o), 32'd8);

    // ready on lane 0: one leaves
    drive(2'b00, 32'h0, 2'b01, 1'b0);
    tick();
    chk("one_deq_count", 32'(count_o), 32'd7);
    chk("one_deq_pc0", deq_uop_o[0].pc, 32'h8000_0004);
    chk("one_deq_pc1", deq_uop_o[1].pc, 32'h8000_0008);
    chk("one_deq_rd", 32'(deq_prd_o[0].rd), 32'd1);

    // credit: count 7 blocks the group even though two leave this cycle
    drive(2'b11, 32'hDEAD_0000, 2'b11, 1'b0);
    #1;
    chk("credit_enq_ready", 32'(enq_ready_o), 32'd0);
    tick();
    chk("credit_count", 32'(count_o), 32'd5);
    chk("credit_head_pc", deq_uop_o[0].pc, 32'h8000_000C);

    // steady 2-in/2-out across several wraps
    exp_pc = 32'h8000_000C;
    enq_pc = 32'h8000_0020;
    for (int k = 0; k < 10; k++) begin
      drive(2'b11, enq_pc, 2'b11, 1'b0);
      #1;
      chk("wrap_pc0", deq_uop_o[0].pc, exp_pc);
      chk("wrap_pc1", deq_uop_o[1].pc, exp_pc + 32'd4);
      tick();
      exp_pc = exp_pc + 32'd8;
      enq_pc = enq_pc + 32'd8;
    end
    drive(2'b00, 32'h0, 2'b00, 1'b0);
    #1;
    chk("wrap_count", 32'(count_o), 32'd5);
    chk("wrap_after_pc", deq_uop_o[0].pc, exp_pc);

    // flush with an enqueue offered in the same cycle
    drive(2'b11, 32'hBAD0_0000, 2'b11, 1'b1);
    #1;
    chk("flush_cycle_valid", 32'(deq_valid_o), 32'd3);
    tick();
    chk("flush_count", 32'(count_o), 32'd0);
    chk("flush_empty", 32'(empty_o), 32'd1);
    chk("flush_deq_valid", 32'(deq_valid_o), 32'd0);
    drive(2'b01, 32'h9000_0000, 2'b00, 1'b0);
    tick();
    chk("post_flush_valid", 32'(deq_valid_o), 32'd1);
    chk("post_flush_pc", deq_uop_o[0].pc, 32'h9000_0000);

    // build to 5 again, then reset with an enqueue offered
    drive(2'b11, 32'h9000_0008, 2'b00, 1'b0);
    tick();
    drive(2'b11, 32'h9000_0010, 2'b00, 1'b0);
    tick();
    chk("prereset_count", 32'(count_o), 32'd5);
    reset = 1'b0;
    drive(2'b11, 32'hBAD0_0100, 2'b00, 1'b0);
    tick();
    reset = 1'b1;
    drive(2'b00, 32'h0, 2'b00, 1'b0);
    #1;
    chk("mid_rst_count", 32'(count_o), 32'd0);
    chk("mid_rst_empty", 32'(empty_o), 32'd1);
    chk("mid_rst_valid", 32'(deq_valid_o), 32'd0);
    chk("mid_rst_ready", 32'(enq_ready_o), 32'd1);
    drive(2'b01, 32'hA000_0000, 2'b00, 1'b0);
    tick();
    chk("post_rst_pc", deq_uop_o[0].pc, 32'hA000_0000);
    chk("post_rst_count", 32'(count_o), 32'd1);
    drive(2'b00, 32'h0, 2'b00, 1'b0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
